ifu: RTL and testbench

Instruction fetch unit for the multi-cycle NPC core: consumes the committed PC, issues one AXI4-Lite-style read per instruction, and hands the fetched word to the IDU with a valid/ready handshake. It also raises the instruction-access-fault flag consumed by the PC-update logic. It sits between the PC register and the IDU, in front of the instruction-memory bus arbiter.

---
 rtl/ifu_pkg.sv | 23 ++
 rtl/ifu_if.sv | 34 +++
 rtl/ifu_stdreg.sv | 19 +
 rtl/ifu.sv | 95 +++++++++
 tb/tb_ifu.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_pkg.sv
// Shared constants for the instruction fetch unit: widths, boot address,
// bus response codes and FSM state encodings.
package ifu_pkg;

  localparam int unsigned CPU_WIDTH = 32;

  localparam logic [CPU_WIDTH-1:0] IFU_RESET_PC = 32'h8000_0000;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  // Instruction words must sit on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [CPU_WIDTH-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_if.sv
// Signal bundle between the IFU and its neighbours: PC input, instruction
// read bus and the IDU handoff. master = IFU side, slave = environment side.
interface ifu_if;
  import ifu_pkg::*;

  logic [CPU_WIDTH-1:0] i_pc;
  logic                 i_pc_valid;
  logic [CPU_WIDTH-1:0] o_araddr;
  logic                 o_arvalid;
  logic                 i_arready;
  logic [CPU_WIDTH-1:0] i_rdata;
  logic [1:0]           i_rresp;
  logic                 i_rvalid;
  logic                 o_rready;
  logic [CPU_WIDTH-1:0] o_inst;
  logic                 o_ifu_valid;
  logic                 i_idu_ready;
  logic                 o_ifu_access_fault;
  logic                 o_busy;
  logic [31:0]          o_fetch_cnt;

  modport master (
    input  i_pc, i_pc_valid, i_arready, i_rdata, i_rresp, i_rvalid, i_idu_ready,
    output o_araddr, o_arvalid, o_rready, o_inst, o_ifu_valid,
           o_ifu_access_fault, o_busy, o_fetch_cnt
  );

  modport slave (
    output i_pc, i_pc_valid, i_arready, i_rdata, i_rresp, i_rvalid, i_idu_ready,
    input  o_araddr, o_arvalid, o_rready, o_inst, o_ifu_valid,
           o_ifu_access_fault, o_busy, o_fetch_cnt
  );

endinterface

// File: rtl/ifu_stdreg.sv
// Plain register with write enable and asynchronous reset.
module ifu_stdreg #(
  parameter int unsigned WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  // Load on write enable, otherwise hold.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     o_q <= RESET_VAL;
    else if (i_we) o_q <= i_d;
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: one bus read per committed PC, result handed to
// the IDU under valid/ready. A misaligned PC faults without touching the bus.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [CPU_WIDTH-1:0] RESET_PC = IFU_RESET_PC
) (
  input logic   i_clk,
  input logic   i_rst,
  ifu_if.master bus
);

  logic [1:0]           state_reg, state_next;
  logic                 boot_pending_reg;
  logic [CPU_WIDTH-1:0] araddr_reg;
  logic [31:0]          fetch_cnt_reg;

  logic                 launch;
  logic [CPU_WIDTH-1:0] launch_addr;
  logic                 launch_misaligned;
  logic                 rd_done;
  logic                 idu_done;
  logic                 rd_fault;

  logic                 hold_we;
  logic [CPU_WIDTH:0]   hold_d;
  logic [CPU_WIDTH:0]   hold_q;

  assign launch            = (state_reg == ST_IDLE) && (boot_pending_reg || bus.i_pc_valid);
  assign launch_addr       = boot_pending_reg ? RESET_PC : bus.i_pc;
  assign launch_misaligned = launch && is_misaligned(launch_addr);
  assign rd_done           = (state_reg == ST_DATA) && bus.i_rvalid;
  assign idu_done          = (state_reg == ST_HOLD) && bus.i_idu_ready;
  assign rd_fault          = bus.i_rresp != RESP_OKAY;

  // Next-state logic for the fetch FSM.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (launch) state_next = launch_misaligned ? ST_HOLD : ST_ADDR;
      ST_ADDR: if (bus.i_arready) state_next = ST_DATA;
      ST_DATA: if (bus.i_rvalid) state_next = ST_HOLD;
      ST_HOLD: if (bus.i_idu_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register, boot flag, latched read address and handshake counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg        <= ST_IDLE;
      boot_pending_reg <= 1'b1;
      araddr_reg       <= '0;
      fetch_cnt_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (launch) begin
        boot_pending_reg <= 1'b0;
        araddr_reg       <= launch_addr;
      end
      if (idu_done) fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
    end
  end

  // Fault bit and instruction word are captured together; a faulting fetch
  // always presents a zero instruction so bus garbage never reaches the IDU.
  always_comb begin
    hold_we = launch_misaligned || rd_done;
    hold_d  = '0;
    if (launch_misaligned) hold_d = {1'b1, {CPU_WIDTH{1'b0}}};
    else if (rd_fault)     hold_d = {1'b1, {CPU_WIDTH{1'b0}}};
    else                   hold_d = {1'b0, bus.i_rdata};
  end

  ifu_stdreg #(
    .WIDTH     (CPU_WIDTH + 1),
    .RESET_VAL ('0)
  ) u_hold_reg (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_we  (hold_we),
    .i_d   (hold_d),
    .o_q   (hold_q)
  );

  assign bus.o_araddr           = araddr_reg;
  assign bus.o_arvalid          = state_reg == ST_ADDR;
  assign bus.o_rready           = state_reg == ST_DATA;
  assign bus.o_ifu_valid        = state_reg == ST_HOLD;
  assign bus.o_busy             = state_reg != ST_IDLE;
  assign bus.o_inst             = hold_q[CPU_WIDTH-1:0];
  assign bus.o_ifu_access_fault = hold_q[CPU_WIDTH];
  assign bus.o_fetch_cnt        = fetch_cnt_reg;

endmodule

// File: tb/tb_ifu.sv
// Directed bench for the instruction fetch unit.
`timescale 1ns/1ps
module tb_ifu;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  ifu_if bus ();

  ifu dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_pc        = '0;
    bus.i_pc_valid  = 1'b0;
    bus.i_arready   = 1'b0;
    bus.i_rdata     = '0;
    bus.i_rresp     = 2'b00;
    bus.i_rvalid    = 1'b0;
    bus.i_idu_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if ({bus.o_araddr, bus.o_inst, bus.o_fetch_cnt} !== 96'h0) begin
      n_errors++;
      $display("FAIL reset_words araddr=%h inst=%h cnt=%h required 0", bus.o_araddr, bus.o_inst, bus.o_fetch_cnt);
    end
    n_checks++;
    if ({bus.o_arvalid, bus.o_rready, bus.o_ifu_valid, bus.o_ifu_access_fault, bus.o_busy} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_flags arvalid=%b rready=%b valid=%b fault=%b busy=%b required 0",
               bus.o_arvalid, bus.o_rready, bus.o_ifu_valid, bus.o_ifu_access_fault, bus.o_busy);
    end
    rst = 1'b0;
  endtask

  // Boot fetch with no i_pc_valid, zero wait states; expected count after it.
  task automatic test_boot(input logic [31:0] exp_cnt);
    step();
    n_checks++;
    if (bus.o_arvalid !== 1'b1 || bus.o_araddr !== 32'h8000_0000) begin
      n_errors++;
      $display("FAIL boot_addr arvalid=%b araddr=%h required 1/80000000", bus.o_arvalid, bus.o_araddr);
    end
    bus.i_arready = 1'b1;
    step();
    bus.i_arready = 1'b0;
    n_checks++;
    if (bus.o_rready !== 1'b1 || bus.o_arvalid !== 1'b0) begin
      n_errors++;
      $display("FAIL boot_data rready=%b arvalid=%b required 1/0", bus.o_rready, bus.o_arvalid);
    end
    bus.i_rvalid = 1'b1;
    bus.i_rdata  = 32'h0000_0413;
    bus.i_rresp  = 2'b00;
    step();
    bus.i_rvalid = 1'b0;
    bus.i_rdata  = 32'h0;
    n_checks++;
    if (bus.o_ifu_valid !== 1'b1 || bus.o_inst !== 32'h0000_0413 || bus.o_ifu_access_fault !== 1'b0) begin
      n_errors++;
      $display("FAIL boot_inst valid=%b inst=%h fault=%b required 1/00000413/0",
               bus.o_ifu_valid, bus.o_inst, bus.o_ifu_access_fault);
    end
    bus.i_idu_ready = 1'b1;
    step();
    bus.i_idu_ready = 1'b0;
    n_checks++;
    if (bus.o_busy !== 1'b0 || bus.o_fetch_cnt !== exp_cnt) begin
      n_errors++;
      $display("FAIL boot_cnt busy=%b cnt=%h required 0/%h", bus.o_busy, bus.o_fetch_cnt, exp_cnt);
    end
    $display("boot fetch addr=80000000 inst=%h cnt=%0d", bus.o_inst, bus.o_fetch_cnt);
  endtask

  task automatic test_wait_states();
    int bad;
    bus.i_pc       = 32'h8000_0100;
    bus.i_pc_valid = 1'b1;
    step();
    bus.i_pc_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.o_arvalid !== 1'b1 || bus.o_araddr !== 32'h8000_0100) bad++;
      step();
    end
    n_checks++;
    if (bad != 0 || bus.o_arvalid !== 1'b1 || bus.o_araddr !== 32'h8000_0100) begin
      n_errors++;
      $display("FAIL ws_addr_stable bad_cycles=%0d araddr=%h required 0/80000100", bad, bus.o_araddr);
    end
    bus.i_arready = 1'b1;
    step();
    bus.i_arready = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.o_rready !== 1'b1 || bus.o_ifu_valid !== 1'b0 || bus.o_arvalid !== 1'b0) bad++;
      step();
    end
    n_checks++;
    if (bad != 0 || bus.o_rready !== 1'b1) begin
      n_errors++;
      $display("FAIL ws_data_wait bad_cycles=%0d rready=%b required 0/1", bad, bus.o_rready);
    end
    bus.i_rvalid = 1'b1;
    bus.i_rdata  = 32'h0010_0093;
    step();
    bus.i_rvalid = 1'b0;
    n_checks++;
    if (bus.o_ifu_valid !== 1'b1 || bus.o_inst !== 32'h0010_0093 || bus.o_ifu_access_fault !== 1'b0) begin
      n_errors++;
      $display("FAIL ws_inst valid=%b inst=%h fault=%b required 1/00100093/0",
               bus.o_ifu_valid, bus.o_inst, bus.o_ifu_access_fault);
    end
    bus.i_idu_ready = 1'b1;
    step();
    bus.i_idu_ready = 1'b0;
    n_checks++;
    if (bus.o_fetch_cnt !== 32'd2 || bus.o_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL ws_cnt cnt=%0d busy=%b required 2/0", bus.o_fetch_cnt, bus.o_busy);
    end
    $display("wait-state fetch addr=80000100 inst=%h cnt=%0d", bus.o_inst, bus.o_fetch_cnt);
  endtask

  task automatic test_bus_error();
    bus.i_pc       = 32'h8000_0200;
    bus.i_pc_valid = 1'b1;
    step();
    bus.i_pc_valid = 1'b0;
    bus.i_arready  = 1'b1;
    step();
    bus.i_arready = 1'b0;
    bus.i_rvalid  = 1'b1;
    bus.i_rresp   = 2'b10;
    bus.i_rdata   = 32'hDEAD_BEEF;
    step();
    bus.i_rvalid = 1'b0;
    bus.i_rresp  = 2'b00;
    bus.i_rdata  = 32'h0;
    n_checks++;
    if (bus.o_ifu_valid !== 1'b1 || bus.o_ifu_access_fault !== 1'b1 || bus.o_inst !== 32'h0) begin
      n_errors++;
      $display("FAIL bus_error valid=%b fault=%b inst=%h required 1/1/00000000",
               bus.o_ifu_valid, bus.o_ifu_access_fault, bus.o_inst);
    end
    bus.i_idu_ready = 1'b1;
    step();
    bus.i_idu_ready = 1'b0;
    n_checks++;
    if (bus.o_fetch_cnt !== 32'd3) begin
      n_errors++;
      $display("FAIL bus_error_cnt cnt=%0d required 3", bus.o_fetch_cnt);
    end
    $display("bus-error fetch addr=80000200 fault=%b cnt=%0d", bus.o_ifu_access_fault, bus.o_fetch_cnt);
  endtask

  // Misaligned PC, with i_idu_ready already high when valid first rises.
  task automatic test_misaligned();
    bus.i_pc        = 32'h8000_0002;
    bus.i_pc_valid  = 1'b1;
    bus.i_idu_ready = 1'b1;
    step();
    bus.i_pc_valid = 1'b0;
    n_checks++;
    if (bus.o_arvalid !== 1'b0 || bus.o_ifu_valid !== 1'b1 || bus.o_ifu_access_fault !== 1'b1 || bus.o_inst !== 32'h0) begin
      n_errors++;
      $display("FAIL misaligned arvalid=%b valid=%b fault=%b inst=%h required 0/1/1/00000000",
               bus.o_arvalid, bus.o_ifu_valid, bus.o_ifu_access_fault, bus.o_inst);
    end
    step();
    bus.i_idu_ready = 1'b0;
    n_checks++;
    if (bus.o_busy !== 1'b0 || bus.o_fetch_cnt !== 32'd4) begin
      n_errors++;
      $display("FAIL misaligned_cnt busy=%b cnt=%0d required 0/4", bus.o_busy, bus.o_fetch_cnt);
    end
    $display("misaligned fetch addr=80000002 fault=1 cnt=%0d", bus.o_fetch_cnt);
  endtask

  task automatic test_backpressure();
    int bad;
    bus.i_pc       = 32'h8000_0300;
    bus.i_pc_valid = 1'b1;
    step();
    bus.i_pc_valid = 1'b0;
    bus.i_arready  = 1'b1;
    step();
    bus.i_arready = 1'b0;
    bus.i_rvalid  = 1'b1;
    bus.i_rdata   = 32'h1234_5678;
    step();
    bus.i_rvalid = 1'b0;
    bus.i_rdata  = 32'hFFFF_FFFF;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.o_ifu_valid !== 1'b1 || bus.o_inst !== 32'h1234_5678 || bus.o_ifu_access_fault !== 1'b0 ||
          bus.o_fetch_cnt !== 32'd4 || bus.o_arvalid !== 1'b0) bad++;
      if (i == 1) begin
        bus.i_pc       = 32'h8000_0400;
        bus.i_pc_valid = 1'b1;
        $display("note: i_pc_valid pulsed during HOLD (protocol violation, expected to be ignored)");
      end else begin
        bus.i_pc_valid = 1'b0;
      end
      step();
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL backpressure_hold bad_cycles=%0d required 0", bad);
    end
    bus.i_idu_ready = 1'b1;
    step();
    bus.i_idu_ready = 1'b0;
    n_checks++;
    if (bus.o_fetch_cnt !== 32'd5 || bus.o_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL backpressure_cnt cnt=%0d busy=%b required 5/0", bus.o_fetch_cnt, bus.o_busy);
    end
    step();
    n_checks++;
    if (bus.o_busy !== 1'b0 || bus.o_arvalid !== 1'b0 || bus.o_araddr !== 32'h8000_0300) begin
      n_errors++;
      $display("FAIL backpressure_ignored busy=%b araddr=%h required 0/80000300", bus.o_busy, bus.o_araddr);
    end
    $display("backpressure fetch addr=80000300 inst=12345678 cnt=%0d", bus.o_fetch_cnt);
  endtask

  // Slave and IDU always ready; a new PC every first IDLE cycle.
  task automatic test_back_to_back();
    logic [31:0] words [2];
    words[0] = 32'h00A0_0513;
    words[1] = 32'h00B0_0593;
    bus.i_arready   = 1'b1;
    bus.i_rvalid    = 1'b1;
    bus.i_idu_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.i_pc       = 32'h8000_0500 + 32'(k * 4);
      bus.i_pc_valid = 1'b1;
      bus.i_rdata    = words[k];
      step();
      bus.i_pc_valid = 1'b0;
      n_checks++;
      if (bus.o_arvalid !== 1'b1 || bus.o_araddr !== 32'h8000_0500 + 32'(k * 4)) begin
        n_errors++;
        $display("FAIL b2b_addr%0d arvalid=%b araddr=%h required 1/%h", k, bus.o_arvalid, bus.o_araddr,
                 32'h8000_0500 + 32'(k * 4));
      end
      step();
      step();
      n_checks++;
      if (bus.o_ifu_valid !== 1'b1 || bus.o_inst !== words[k]) begin
        n_errors++;
        $display("FAIL b2b_inst%0d valid=%b inst=%h required 1/%h", k, bus.o_ifu_valid, bus.o_inst, words[k]);
      end
      step();
      $display("back-to-back fetch %0d inst=%h cnt=%0d", k, words[k], bus.o_fetch_cnt);
    end
    n_checks++;
    if (bus.o_fetch_cnt !== 32'd7 || bus.o_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_cnt cnt=%0d busy=%b required 7/0", bus.o_fetch_cnt, bus.o_busy);
    end
    idle_inputs();
  endtask

  task automatic test_reset_in_data();
    int cyc;
    bus.i_pc       = 32'h8000_0600;
    bus.i_pc_valid = 1'b1;
    step();
    bus.i_pc_valid = 1'b0;
    bus.i_arready  = 1'b1;
    step();
    bus.i_arready = 1'b0;
    n_checks++;
    if (bus.o_rready !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_reach_data rready=%b required 1", bus.o_rready);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.o_araddr, bus.o_inst, bus.o_fetch_cnt} !== 96'h0 ||
        {bus.o_arvalid, bus.o_rready, bus.o_ifu_valid, bus.o_ifu_access_fault, bus.o_busy} !== 5'b0) begin
      n_errors++;
      $display("FAIL rst_mid_outputs araddr=%h rready=%b busy=%b cnt=%0d required all 0",
               bus.o_araddr, bus.o_rready, bus.o_busy, bus.o_fetch_cnt);
    end
    step();
    rst = 1'b0;
    test_boot(32'd1);

    force dut.fetch_cnt_reg = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_cnt_reg;
    #1;
    bus.i_pc       = 32'h8000_0700;
    bus.i_pc_valid = 1'b1;
    bus.i_arready  = 1'b1;
    bus.i_rvalid   = 1'b1;
    bus.i_rdata    = 32'h0000_0013;
    step();
    bus.i_pc_valid = 1'b0;
    cyc = 0;
    while (bus.o_ifu_valid !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    n_checks++;
    if (bus.o_ifu_valid !== 1'b1 || bus.o_fetch_cnt !== 32'hFFFF_FFFF) begin
      n_errors++;
      $display("FAIL wrap_pre valid=%b cnt=%h required 1/ffffffff", bus.o_ifu_valid, bus.o_fetch_cnt);
    end
    bus.i_idu_ready = 1'b1;
    step();
    idle_inputs();
    n_checks++;
    if (bus.o_fetch_cnt !== 32'h0) begin
      n_errors++;
      $display("FAIL wrap cnt=%h required 00000000", bus.o_fetch_cnt);
    end
    $display("wrap fetch addr=80000700 cnt=%h", bus.o_fetch_cnt);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    test_reset();
    test_boot(32'd1);
    test_wait_states();
    test_bus_error();
    test_misaligned();
    test_backpressure();
    test_back_to_back();
    test_reset_in_data();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
